// File: rtl/biriscv_issue_ctrl_if.sv
// Decode-to-issue handshake bundle for the dual-slot issue controller.
//   slotN_valid_i    : slot N holds an instruction (slot1 is the younger one)
//   slotN_class_i    : {csr,div,mul,branch,lsu,exec} class flags from the decoder
//   slotN_rd_valid_i : slot N writes rd
//   slotN_regs_i     : {rd[14:10], ra[9:5], rb[4:0]}
//   slotN_store_i    : slot N lsu op is a store (no rd)
//   issue0_o/issue1_o: slot accepted this cycle
// master = decode side, slave = issue controller.
interface biriscv_issue_ctrl_if;
  logic        slot0_valid_i;
  logic [5:0]  slot0_class_i;
  logic        slot0_rd_valid_i;
  logic [14:0] slot0_regs_i;
  logic        slot0_store_i;
  logic        slot1_valid_i;
  logic [5:0]  slot1_class_i;
  logic        slot1_rd_valid_i;
  logic [14:0] slot1_regs_i;
  logic        slot1_store_i;
  logic        issue0_o;
  logic        issue1_o;

  modport master (
    output slot0_valid_i, slot0_class_i, slot0_rd_valid_i, slot0_regs_i, slot0_store_i,
    output slot1_valid_i, slot1_class_i, slot1_rd_valid_i, slot1_regs_i, slot1_store_i,
    input  issue0_o, issue1_o
  );

  modport slave (
    input  slot0_valid_i, slot0_class_i, slot0_rd_valid_i, slot0_regs_i, slot0_store_i,
    input  slot1_valid_i, slot1_class_i, slot1_rd_valid_i, slot1_regs_i, slot1_store_i,
    output issue0_o, issue1_o
  );
endinterface

// File: rtl/biriscv_issue_ctrl.sv
// Dual-slot issue controller. Decides each cycle whether slot0 alone, both
// slots, or neither issue, enforcing the single LSU/multiplier/divider/CSR
// limits and RAW/WAW interlocks against a per-register scoreboard of pending
// long-latency results (load, mul, div).
// Ports:
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   dec              : decode slots in, issue0_o/issue1_o out (slave modport)
//   stall_i          : downstream frozen; no issue, scoreboard counters hold
//   flush_i          : kill decode contents (suppresses issue only)
//   div_complete_i   : divider writeback strobe
//   div_busy_o       : divide in flight
//   sb_pending_o     : per-register pending bit (bit0 always 0)
module biriscv_issue_ctrl #(
  parameter int unsigned DUAL_ISSUE   = 1,
  parameter int unsigned LOAD_LATENCY = 2,
  parameter int unsigned MUL_LATENCY  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  biriscv_issue_ctrl_if.slave       dec,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      div_complete_i,
  output logic                      div_busy_o,
  output logic [31:0]               sb_pending_o
);

  typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;

  div_state_t  div_state_q;
  logic [4:0]  div_idx_q;
  logic [2:0]  cnt_q [32];
  logic [2:0]  cnt_d [32];
  logic [31:0] pending;

  logic [4:0] rd0, ra0, rb0, rd1, ra1, rb1;
  logic       lsu0, mul0, div0, br0, csr0;
  logic       lsu1, mul1, div1, csr1;
  logic       sb_ok0, sb_ok1, raw01, waw01;
  logic       issue0, issue1;
  logic       load_set0, mul_set0, load_set1, mul_set1, div_set;

  assign rd0  = dec.slot0_regs_i[14:10];
  assign ra0  = dec.slot0_regs_i[9:5];
  assign rb0  = dec.slot0_regs_i[4:0];
  assign rd1  = dec.slot1_regs_i[14:10];
  assign ra1  = dec.slot1_regs_i[9:5];
  assign rb1  = dec.slot1_regs_i[4:0];

  assign lsu0 = dec.slot0_class_i[1];
  assign br0  = dec.slot0_class_i[2];
  assign mul0 = dec.slot0_class_i[3];
  assign div0 = dec.slot0_class_i[4];
  assign csr0 = dec.slot0_class_i[5];
  assign lsu1 = dec.slot1_class_i[1];
  assign mul1 = dec.slot1_class_i[3];
  assign div1 = dec.slot1_class_i[4];
  assign csr1 = dec.slot1_class_i[5];

  // exec class never constrains issue; slot1 branch is unrestricted
  logic unused_class;
  assign unused_class = dec.slot0_class_i[0] ^ dec.slot1_class_i[0] ^ dec.slot1_class_i[2];

  assign div_busy_o = (div_state_q == DIV_BUSY);

  // x0 is skipped so it can never hazard
  always_comb begin
    pending = '0;
    for (int unsigned r = 1; r < 32; r++) begin
      pending[r] = (cnt_q[r] != '0) || (div_busy_o && (div_idx_q == 5'(r)));
    end
  end

  assign sb_pending_o = pending;

  assign sb_ok0 = !pending[ra0] && !pending[rb0] && !(dec.slot0_rd_valid_i && pending[rd0]);
  assign sb_ok1 = !pending[ra1] && !pending[rb1] && !(dec.slot1_rd_valid_i && pending[rd1]);

  assign raw01  = dec.slot0_rd_valid_i && (rd0 != '0) && ((ra1 == rd0) || (rb1 == rd0));
  assign waw01  = dec.slot0_rd_valid_i && dec.slot1_rd_valid_i && (rd0 != '0) && (rd1 == rd0);

  // rst_ni gates issue so nothing is accepted while reset is held
  assign issue0 = rst_ni && dec.slot0_valid_i && !stall_i && !flush_i && sb_ok0 &&
                  !(div0 && div_busy_o);

  assign issue1 = (DUAL_ISSUE != 0) && issue0 && dec.slot1_valid_i &&
                  !csr1 && !div1 && !csr0 && !br0 &&
                  !(lsu0 && lsu1) && !(mul0 && mul1) &&
                  sb_ok1 && !raw01 && !waw01;

  assign dec.issue0_o = issue0;
  assign dec.issue1_o = issue1;

  assign load_set0 = issue0 && lsu0 && dec.slot0_rd_valid_i && !dec.slot0_store_i;
  assign mul_set0  = issue0 && mul0 && dec.slot0_rd_valid_i;
  assign load_set1 = issue1 && lsu1 && dec.slot1_rd_valid_i && !dec.slot1_store_i;
  assign mul_set1  = issue1 && mul1 && dec.slot1_rd_valid_i;
  assign div_set   = issue0 && div0 && dec.slot0_rd_valid_i;

  // A latency load on issue takes priority over the decrement of the same entry
  always_comb begin
    cnt_d[0] = '0;
    for (int unsigned r = 1; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!stall_i && (cnt_q[r] != '0)) cnt_d[r] = cnt_q[r] - 3'd1;
      if (load_set0 && (rd0 == 5'(r))) cnt_d[r] = 3'(LOAD_LATENCY);
      if (mul_set0  && (rd0 == 5'(r))) cnt_d[r] = 3'(MUL_LATENCY);
      if (load_set1 && (rd1 == 5'(r))) cnt_d[r] = 3'(LOAD_LATENCY);
      if (mul_set1  && (rd1 == 5'(r))) cnt_d[r] = 3'(MUL_LATENCY);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  // A new div cannot issue while busy, so set and complete never collide;
  // a complete strobe while idle is simply ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_state_q <= DIV_IDLE;
      div_idx_q   <= '0;
    end else begin
      case (div_state_q)
        DIV_IDLE: begin
          if (div_set) begin
            div_state_q <= DIV_BUSY;
            div_idx_q   <= rd0;
          end
        end
        DIV_BUSY: begin
          if (div_complete_i) div_state_q <= DIV_IDLE;
        end
        default: div_state_q <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biriscv_issue_ctrl.sv
// Directed-vector bench for biriscv_issue_ctrl: the stimulus process queues
// the expected issue/scoreboard state for every cycle it drives, and a monitor
// on the falling edge pops and compares. A second instance built with
// DUAL_ISSUE=0 covers the single-issue configuration.
module tb_biriscv_issue_ctrl;

  localparam logic [5:0] C_EXEC = 6'b000001;
  localparam logic [5:0] C_LSU  = 6'b000010;
  localparam logic [5:0] C_BR   = 6'b000100;
  localparam logic [5:0] C_MUL  = 6'b001000;
  localparam logic [5:0] C_DIV  = 6'b010000;
  localparam logic [5:0] C_CSR  = 6'b100000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, divc;
  logic        busy, s_busy;
  logic [31:0] pend, s_pend;

  biriscv_issue_ctrl_if dbus();
  biriscv_issue_ctrl_if sbus();

  biriscv_issue_ctrl #(.DUAL_ISSUE(1), .LOAD_LATENCY(2), .MUL_LATENCY(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .dec(dbus), .stall_i(stall), .flush_i(flush),
    .div_complete_i(divc), .div_busy_o(busy), .sb_pending_o(pend)
  );

  biriscv_issue_ctrl #(.DUAL_ISSUE(0), .LOAD_LATENCY(2), .MUL_LATENCY(2)) dut_single (
    .clk_i(clk), .rst_ni(rst_n), .dec(sbus), .stall_i(stall), .flush_i(flush),
    .div_complete_i(divc), .div_busy_o(s_busy), .sb_pending_o(s_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        e0;
    logic        e1;
    logic        eb;
    logic [31:0] ep;
    logic        es0;
    logic        es1;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] b(input int n);
    return 32'h1 << n;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({e.name, ".issue0"},   32'(dbus.issue0_o), 32'(e.e0));
      chk({e.name, ".issue1"},   32'(dbus.issue1_o), 32'(e.e1));
      chk({e.name, ".div_busy"}, 32'(busy),          32'(e.eb));
      chk({e.name, ".pending"},  pend,               e.ep);
      chk({e.name, ".s_issue0"}, 32'(sbus.issue0_o), 32'(e.es0));
      chk({e.name, ".s_issue1"}, 32'(sbus.issue1_o), 32'(e.es1));
    end
  end

  task automatic clr();
    dbus.slot0_valid_i = 0; dbus.slot0_class_i = '0; dbus.slot0_rd_valid_i = 0;
    dbus.slot0_regs_i = '0; dbus.slot0_store_i = 0;
    dbus.slot1_valid_i = 0; dbus.slot1_class_i = '0; dbus.slot1_rd_valid_i = 0;
    dbus.slot1_regs_i = '0; dbus.slot1_store_i = 0;
    sbus.slot0_valid_i = 0; sbus.slot0_class_i = '0; sbus.slot0_rd_valid_i = 0;
    sbus.slot0_regs_i = '0; sbus.slot0_store_i = 0;
    sbus.slot1_valid_i = 0; sbus.slot1_class_i = '0; sbus.slot1_rd_valid_i = 0;
    sbus.slot1_regs_i = '0; sbus.slot1_store_i = 0;
    stall = 0; flush = 0; divc = 0;
  endtask

  task automatic s0(input logic [5:0] c, input logic rdv, input logic [4:0] rd,
                    input logic [4:0] ra, input logic [4:0] rb, input logic st = 1'b0);
    dbus.slot0_valid_i = 1; dbus.slot0_class_i = c; dbus.slot0_rd_valid_i = rdv;
    dbus.slot0_regs_i = {rd, ra, rb}; dbus.slot0_store_i = st;
  endtask

  task automatic s1(input logic [5:0] c, input logic rdv, input logic [4:0] rd,
                    input logic [4:0] ra, input logic [4:0] rb, input logic st = 1'b0);
    dbus.slot1_valid_i = 1; dbus.slot1_class_i = c; dbus.slot1_rd_valid_i = rdv;
    dbus.slot1_regs_i = {rd, ra, rb}; dbus.slot1_store_i = st;
  endtask

  task automatic step(input string n, input logic e0, input logic e1, input logic eb,
                      input logic [31:0] ep, input logic es0 = 1'b0, input logic es1 = 1'b0);
    exp_t e;
    e.name = n; e.e0 = e0; e.e1 = e1; e.eb = eb; e.ep = ep; e.es0 = es0; e.es1 = es1;
    q.push_back(e);
    @(posedge clk);
    #1;
    clr();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    rst_n = 0;
    @(posedge clk);
    #1;
    // reset held: valid slots must not issue, state clear
    s0(C_EXEC, 1, 5'd1, 5'd0, 5'd0);
    sbus.slot0_valid_i = 1; sbus.slot0_class_i = C_EXEC;
    step("reset", 0, 0, 0, '0);
    rst_n = 1;

    // independent ALU pair dual-issues; single-issue instance takes slot0 only
    s0(C_EXEC, 1, 5'd1, 5'd0, 5'd0);
    s1(C_EXEC, 1, 5'd2, 5'd3, 5'd4);
    sbus.slot0_valid_i = 1; sbus.slot0_class_i = C_EXEC; sbus.slot0_rd_valid_i = 1;
    sbus.slot0_regs_i = {5'd1, 5'd0, 5'd0};
    sbus.slot1_valid_i = 1; sbus.slot1_class_i = C_EXEC; sbus.slot1_rd_valid_i = 1;
    sbus.slot1_regs_i = {5'd2, 5'd3, 5'd4};
    step("alu_pair", 1, 1, 0, '0, 1, 0);

    // load-use interlock, LOAD_LATENCY=2
    s0(C_LSU, 1, 5'd5, 5'd1, 5'd0);
    step("lw_x5", 1, 0, 0, '0);
    s0(C_EXEC, 1, 5'd6, 5'd5, 5'd0);
    step("use_blk1", 0, 0, 0, b(5));
    s0(C_EXEC, 1, 5'd6, 5'd5, 5'd0);
    step("use_blk2", 0, 0, 0, b(5));
    s0(C_EXEC, 1, 5'd6, 5'd5, 5'd0);
    step("use_go", 1, 0, 0, '0);

    // single multiplier
    s0(C_MUL, 1, 5'd7, 5'd1, 5'd2);
    s1(C_MUL, 1, 5'd8, 5'd1, 5'd2);
    step("mul_pair", 1, 0, 0, '0);
    s0(C_MUL, 1, 5'd8, 5'd1, 5'd2);
    step("mul_retry", 1, 0, 0, b(7));

    // divider busy and completion
    s0(C_DIV, 1, 5'd9, 5'd1, 5'd2);
    step("div_x9", 1, 0, 0, b(7) | b(8));
    s0(C_DIV, 1, 5'd10, 5'd1, 5'd2);
    step("div_blk1", 0, 0, 1, b(8) | b(9));
    s0(C_DIV, 1, 5'd10, 5'd1, 5'd2);
    step("div_blk2", 0, 0, 1, b(9));
    s0(C_DIV, 1, 5'd10, 5'd1, 5'd2);
    divc = 1;
    step("div_cmpl_cyc", 0, 0, 1, b(9));
    s0(C_DIV, 1, 5'd10, 5'd1, 5'd2);
    step("div_x10", 1, 0, 0, '0);
    divc = 1;
    step("div10_cmpl", 0, 0, 1, b(10));
    divc = 1;
    step("stray_cmpl", 0, 0, 0, '0);
    step("div_idle", 0, 0, 0, '0);

    // pairing restrictions
    s0(C_EXEC, 1, 5'd3, 5'd1, 5'd0);
    s1(C_EXEC, 1, 5'd4, 5'd3, 5'd1);
    step("pair_raw", 1, 0, 0, '0);
    s0(C_CSR, 1, 5'd11, 5'd1, 5'd0);
    s1(C_EXEC, 1, 5'd12, 5'd13, 5'd14);
    step("pair_csr0", 1, 0, 0, '0);
    s0(C_BR, 0, 5'd0, 5'd1, 5'd2);
    s1(C_EXEC, 1, 5'd12, 5'd13, 5'd14);
    step("pair_br0", 1, 0, 0, '0);
    s0(C_LSU, 1, 5'd13, 5'd1, 5'd0);
    s1(C_LSU, 0, 5'd0, 5'd2, 5'd3, 1);
    step("pair_lsu", 1, 0, 0, '0);
    s0(C_EXEC, 1, 5'd14, 5'd1, 5'd2);
    s1(C_EXEC, 1, 5'd14, 5'd3, 5'd4);
    step("pair_waw", 1, 0, 0, b(13));
    s0(C_EXEC, 1, 5'd15, 5'd1, 5'd2);
    s1(C_EXEC, 1, 5'd17, 5'd13, 5'd0);
    step("pair_sb1", 1, 0, 0, b(13));
    s0(C_EXEC, 1, 5'd15, 5'd1, 5'd2);
    s1(C_DIV, 1, 5'd16, 5'd1, 5'd2);
    step("pair_div1", 1, 0, 0, '0);
    s0(C_EXEC, 1, 5'd18, 5'd1, 5'd2);
    s1(C_LSU, 1, 5'd19, 5'd1, 5'd0);
    step("pair_lw1", 1, 1, 0, '0);
    s0(C_EXEC, 1, 5'd20, 5'd19, 5'd0);
    step("lw1_use", 0, 0, 0, b(19));
    step("lw1_cnt1", 0, 0, 0, b(19));
    step("lw1_done", 0, 0, 0, '0);

    // stall holds counters, flush only suppresses issue
    s0(C_LSU, 1, 5'd5, 5'd1, 5'd0);
    step("lw_x5b", 1, 0, 0, '0);
    step("cnt2", 0, 0, 0, b(5));
    stall = 1;
    step("stall1", 0, 0, 0, b(5));
    stall = 1; flush = 1;
    s0(C_EXEC, 1, 5'd6, 5'd1, 5'd2);
    step("stall_flush", 0, 0, 0, b(5));
    stall = 1;
    step("stall3", 0, 0, 0, b(5));
    s0(C_EXEC, 1, 5'd6, 5'd5, 5'd0);
    step("post_stall", 0, 0, 0, b(5));
    flush = 1;
    s0(C_EXEC, 1, 5'd7, 5'd1, 5'd2);
    step("flush_only", 0, 0, 0, '0);
    s0(C_DIV, 1, 5'd9, 5'd1, 5'd2);
    step("div_x9b", 1, 0, 0, '0);
    flush = 1;
    step("flush_div", 0, 0, 1, b(9));
    step("div_kept", 0, 0, 1, b(9));
    s0(C_LSU, 1, 5'd5, 5'd1, 5'd0);
    step("lw_x5c", 1, 0, 1, b(9));

    // asynchronous reset mid-count
    rst_n = 0;
    s0(C_EXEC, 1, 5'd6, 5'd5, 5'd0);
    step("async_rst", 0, 0, 0, '0);
    rst_n = 1;
    s0(C_EXEC, 1, 5'd6, 5'd5, 5'd0);
    step("after_rst", 1, 0, 0, '0);

    repeat (3) @(posedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
